// File: rtl/score_meter_pkg.sv
// -----------------------------------------------------------------------------
// score_meter_pkg
// Shared definitions for the score meter:
//   - default parameter values for score_meter and bcd_counter
//   - flash_state_e : flash FSM states (IDLE / OFF / ON)
//   - bcd_t         : one BCD digit
//   - bcd_greater   : digit-wise BCD magnitude compare, most significant first
// -----------------------------------------------------------------------------
package score_meter_pkg;

    localparam int DEF_DIGITS       = 5;
    localparam int DEF_SPEED_W      = 15;
    localparam int DEF_COEFF        = 40960;
    localparam int DEF_ACH_POW      = 2;
    localparam int DEF_FLASH_FRAMES = 15;
    localparam int DEF_FLASH_COUNT  = 3;

    // Widest score supported; bcd_greater works on this many digits.
    localparam int MAX_DIGITS = 8;
    localparam int HI_W       = MAX_DIGITS * 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OFF  = 2'd1,
        ON   = 2'd2
    } flash_state_e;

    typedef logic [3:0] bcd_t;

    // True when a > b. Operands are zero-extended BCD, digit 0 in bits [3:0].
    // The first differing digit from the top decides.
    function automatic logic bcd_greater(input logic [HI_W-1:0] a,
                                         input logic [HI_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt      = (a[i*4 +: 4] > b[i*4 +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_meter_bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// Combinational +1 on a DIGITS-wide BCD value with saturation at all 9s.
//   value_i    : current value, least significant digit in bits [3:0]
//   next_o     : value_i + 1, or value_i unchanged when it is already all 9s
//   carry_o    : carry out of the top digit, i.e. value_i was all 9s
//   low_zero_o : the low ACH_POW digits of next_o are all zero after a real
//                increment (never set while saturated)
// -----------------------------------------------------------------------------
module bcd_counter
    import score_meter_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int ACH_POW = DEF_ACH_POW
) (
    input  logic [DIGITS*4-1:0] value_i,
    output logic [DIGITS*4-1:0] next_o,
    output logic                carry_o,
    output logic                low_zero_o
);

    logic [DIGITS*4-1:0] sum;
    logic                carry;
    bcd_t                d;

    always_comb begin
        sum   = value_i;
        carry = 1'b1;
        d     = '0;
        // Ripple the +1 upward: a 9 rolls to 0 and passes the carry on.
        for (int j = 0; j < DIGITS; j++) begin
            d = value_i[j*4 +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    sum[j*4 +: 4] = 4'd0;
                end else begin
                    sum[j*4 +: 4] = d + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        carry_o    = carry;
        next_o     = carry ? value_i : sum;
        low_zero_o = !carry;
        for (int j = 0; j < ACH_POW; j++) begin
            if (next_o[j*4 +: 4] != 4'd0) low_zero_o = 1'b0;
        end
    end

endmodule

// File: rtl/score_meter.sv
// -----------------------------------------------------------------------------
// score_meter
// Distance-based BCD score with achievement flashing.
// Speed is accumulated on every update tick; each time the accumulator passes
// COEFF the BCD score goes up by one. Reaching a multiple of 10**ACH_POW
// pulses achieve and flashes a snapshot of the score (paint off/on).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   update     one-cycle frame tick
//   speed      current scroll speed; 0 means crashed/paused
//   clear      new-game pulse (beats a simultaneous update)
//   digits     DIGITS x 4 BCD, digit index 0 (most significant) in the top nibble
//   paint      draw-enable, low during the OFF half of a flash
//   achieve    one-cycle pulse on achievement
// Optional (macro SCORE_METER_HI_EN):
//   hi_digits  high score BCD, same layout as digits
//   hi_valid   high score is nonzero
// -----------------------------------------------------------------------------
module score_meter
    import score_meter_pkg::*;
#(
    parameter int DIGITS       = DEF_DIGITS,
    parameter int SPEED_W      = DEF_SPEED_W,
    parameter int COEFF        = DEF_COEFF,
    parameter int ACH_POW      = DEF_ACH_POW,
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
    parameter int FLASH_COUNT  = DEF_FLASH_COUNT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                update,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                clear,
    output logic [DIGITS*4-1:0] digits,
    output logic                paint,
    output logic                achieve
`ifdef SCORE_METER_HI_EN
    ,
    output logic [DIGITS*4-1:0] hi_digits,
    output logic                hi_valid
`endif
);

    // Largest accumulator value is (COEFF-1) + (2**SPEED_W - 1).
    localparam int ACC_W   = $clog2(COEFF + (1 << SPEED_W) - 1);
    localparam int FRAME_W = $clog2(FLASH_FRAMES + 1);
    localparam int ITER_W  = $clog2(FLASH_COUNT + 1);

    localparam logic [ACC_W-1:0]   COEFF_V    = ACC_W'(COEFF);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FLASH_FRAMES - 1);
    localparam logic [ITER_W-1:0]  ITER_LAST  = ITER_W'(FLASH_COUNT - 1);

    logic [DIGITS*4-1:0] score_q;
    logic [DIGITS*4-1:0] snap_q;
    logic [ACC_W-1:0]    acc_q;
    logic [FRAME_W-1:0]  frame_q;
    logic [ITER_W-1:0]   iter_q;
    flash_state_e        state_q;
    logic                paint_q;
    logic                achieve_q;

    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_d;
    logic                wrap;
    logic                speed_zero;
    logic [DIGITS*4-1:0] inc_next;
    logic                inc_sat;
    logic                inc_low_zero;

    assign speed_zero = (speed == '0);
    assign acc_sum    = acc_q + ACC_W'(speed);
    assign wrap       = (acc_sum >= COEFF_V);
    assign acc_d      = wrap ? (acc_sum - COEFF_V) : acc_sum;

    bcd_counter #(
        .DIGITS  (DIGITS),
        .ACH_POW (ACH_POW)
    ) u_inc (
        .value_i    (score_q),
        .next_o     (inc_next),
        .carry_o    (inc_sat),
        .low_zero_o (inc_low_zero)
    );

    // Score, accumulator and flash FSM. Priority: rst > clear > speed 0 > update.
    // Within an update, an achievement overrides the normal flash step so a
    // new achievement always restarts the flash from OFF.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            score_q   <= '0;
            snap_q    <= '0;
            acc_q     <= '0;
            frame_q   <= '0;
            iter_q    <= '0;
            state_q   <= IDLE;
            paint_q   <= 1'b1;
            achieve_q <= 1'b0;
        end else if (speed_zero) begin
            // Crash/pause: hold score and acc, show the live score solidly.
            frame_q   <= '0;
            iter_q    <= '0;
            state_q   <= IDLE;
            paint_q   <= 1'b1;
            achieve_q <= 1'b0;
        end else begin
            achieve_q <= 1'b0;
            if (update) begin
                case (state_q)
                    OFF: begin
                        if (frame_q == FRAME_LAST) begin
                            frame_q <= '0;
                            state_q <= ON;
                            paint_q <= 1'b1;
                        end else begin
                            frame_q <= frame_q + FRAME_W'(1);
                        end
                    end
                    ON: begin
                        if (frame_q == FRAME_LAST) begin
                            frame_q <= '0;
                            if (iter_q == ITER_LAST) begin
                                iter_q  <= '0;
                                state_q <= IDLE;
                            end else begin
                                iter_q  <= iter_q + ITER_W'(1);
                                state_q <= OFF;
                                paint_q <= 1'b0;
                            end
                        end else begin
                            frame_q <= frame_q + FRAME_W'(1);
                        end
                    end
                    default: ;
                endcase

                acc_q <= acc_d;
                if (wrap && !inc_sat) begin
                    score_q <= inc_next;
                    if (inc_low_zero) begin
                        achieve_q <= 1'b1;
                        snap_q    <= inc_next;
                        state_q   <= OFF;
                        frame_q   <= '0;
                        iter_q    <= '0;
                        paint_q   <= 1'b0;
                    end
                end
            end
        end
    end

    assign digits  = (state_q != IDLE) ? snap_q : score_q;
    assign paint   = paint_q;
    assign achieve = achieve_q;

`ifdef SCORE_METER_HI_EN
    logic [DIGITS*4-1:0] hi_q;
    logic                speed_nz_q;

    // End of a run is either a clear or speed dropping to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            speed_nz_q <= 1'b0;
        end else begin
            speed_nz_q <= !speed_zero;
            if ((clear || (speed_nz_q && speed_zero)) &&
                bcd_greater(HI_W'(score_q), HI_W'(hi_q))) begin
                hi_q <= score_q;
            end
        end
    end

    assign hi_digits = hi_q;
    assign hi_valid  = |hi_q;
`endif

endmodule

// File: tb/tb_score_meter.sv
// -----------------------------------------------------------------------------
// tb_score_meter
// Directed bench for score_meter. dut uses the default parameters; dut2 is a
// tiny 2-digit build (COEFF 2, speed 1 => one point every two updates) used
// for saturation and reset-during-flash. Optional high-score ports are
// connected and checked when SCORE_METER_HI_EN is defined.
// -----------------------------------------------------------------------------
module tb_score_meter;

    logic        clk;
    logic        rst;
    logic        update;
    logic [14:0] speed;
    logic        clear;
    logic [19:0] digits;
    logic        paint;
    logic        achieve;

    logic        update2;
    logic [1:0]  speed2;
    logic        clear2;
    logic [7:0]  digits2;
    logic        paint2;
    logic        achieve2;

`ifdef SCORE_METER_HI_EN
    logic [19:0] hi_digits;
    logic        hi_valid;
    logic [7:0]  hi_digits2;
    logic        hi_valid2;
`endif

    int n_assert;
    int n_fail;
    int ach_seen;

    score_meter dut (
        .clk       (clk),
        .rst       (rst),
        .update    (update),
        .speed     (speed),
        .clear     (clear),
        .digits    (digits),
        .paint     (paint),
        .achieve   (achieve)
`ifdef SCORE_METER_HI_EN
        ,
        .hi_digits (hi_digits),
        .hi_valid  (hi_valid)
`endif
    );

    score_meter #(
        .DIGITS       (2),
        .SPEED_W      (2),
        .COEFF        (2),
        .ACH_POW      (1),
        .FLASH_FRAMES (2),
        .FLASH_COUNT  (1)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .update    (update2),
        .speed     (speed2),
        .clear     (clear2),
        .digits    (digits2),
        .paint     (paint2),
        .achieve   (achieve2)
`ifdef SCORE_METER_HI_EN
        ,
        .hi_digits (hi_digits2),
        .hi_valid  (hi_valid2)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One update tick on dut; returns at the negedge after the consuming edge.
    task automatic tick1();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic tick2();
        @(negedge clk);
        update2 = 1'b1;
        @(negedge clk);
        update2 = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        ach_seen = 0;
        rst      = 1'b1;
        update   = 1'b0;
        speed    = '0;
        clear    = 1'b0;
        update2  = 1'b0;
        speed2   = '0;
        clear2   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_digits",   32'(digits),   32'h0);
        chk("rst_paint",    32'(paint),    32'd1);
        chk("rst_achieve",  32'(achieve),  32'd0);
        chk("rst_digits2",  32'(digits2),  32'h0);
        chk("rst_paint2",   32'(paint2),   32'd1);
`ifdef SCORE_METER_HI_EN
        chk("rst_hi",       32'(hi_digits), 32'h0);
        chk("rst_hi_valid", 32'(hi_valid),  32'd0);
`endif

        // 10 x 4096 = 40960: first point exactly on the 10th update
        speed = 15'd4096;
        repeat (9) tick1();
        chk("acc_9_updates", 32'(digits), 32'h00000);
        tick1();
        chk("first_point",        32'(digits),  32'h00001);
        chk("first_point_no_ach", 32'(achieve), 32'd0);

        // 20480 = COEFF/2: 196 updates -> +98 points, acc back at 0
        speed    = 15'd20480;
        ach_seen = 0;
        for (int i = 0; i < 196; i++) begin
            tick1();
            if (achieve) ach_seen++;
        end
        chk("climb_no_ach", 32'(ach_seen), 32'd0);
        chk("climb_99",     32'(digits),   32'h00099);

        // acc 0 -> 20000 -> 40000, still 99
        speed = 15'd20000;
        repeat (2) tick1();
        chk("acc_40000_99", 32'(digits), 32'h00099);

        // 40000 + 4096 crosses COEFF: 100, achievement, acc 3136
        speed = 15'd4096;
        tick1();
        chk("ach_100_digits", 32'(digits),  32'h00100);
        chk("ach_100_pulse",  32'(achieve), 32'd1);
        chk("ach_100_paint",  32'(paint),   32'd0);

        // Flash: 15 updates off, 15 on, three times, then IDLE.
        // 90 x 4096 + 3136 = 9 x 40960 + 3136, so the live score ends at 109.
        for (int k = 1; k <= 90; k++) begin
            tick1();
            if (k == 1) chk("ach_pulse_one_cycle", 32'(achieve), 32'd0);
            chk("flash_paint", 32'(paint),
                32'((k >= 90) || (((k / 15) % 2) == 1)));
            chk("flash_digits", 32'(digits), (k < 90) ? 32'h00100 : 32'h00109);
        end

        // acc alternates 3136 -> 23616 -> 3136 (+1); 182 updates -> +91 -> 200
        speed    = 15'd20480;
        ach_seen = 0;
        for (int i = 0; i < 182; i++) begin
            tick1();
            if (achieve) ach_seen++;
        end
        chk("ach_200_count",  32'(ach_seen), 32'd1);
        chk("ach_200_pulse",  32'(achieve),  32'd1);
        chk("ach_200_digits", 32'(digits),   32'h00200);

        // Two updates in OFF: live score 201, display holds the snapshot
        repeat (2) tick1();
        chk("off_paint",    32'(paint),  32'd0);
        chk("off_snapshot", 32'(digits), 32'h00200);

        // Speed drops to 0 mid-flash
        @(negedge clk);
        speed = '0;
        @(negedge clk);
        chk("crash_paint",  32'(paint),  32'd1);
        chk("crash_digits", 32'(digits), 32'h00201);
        repeat (2) tick1();
        chk("crash_freeze",       32'(digits), 32'h00201);
        chk("crash_freeze_paint", 32'(paint),  32'd1);
`ifdef SCORE_METER_HI_EN
        chk("crash_hi",       32'(hi_digits), 32'h00201);
        chk("crash_hi_valid", 32'(hi_valid),  32'd1);
`endif

        // clear together with update: clear wins
        @(negedge clk);
        speed  = 15'd20000;
        clear  = 1'b1;
        update = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        update = 1'b0;
        chk("clear_digits", 32'(digits), 32'h00000);
`ifdef SCORE_METER_HI_EN
        chk("clear_hi",       32'(hi_digits), 32'h00201);
        chk("clear_hi_valid", 32'(hi_valid),  32'd1);
`endif
        // acc cleared: 20000, 40000 -> no point; 60000 -> 1
        repeat (2) tick1();
        chk("clear_acc_zero", 32'(digits), 32'h00000);
        tick1();
        chk("clear_then_point", 32'(digits), 32'h00001);

        // Saturation on dut2: achievements at 10..90, then hold at 99
        speed2   = 2'd1;
        ach_seen = 0;
        for (int i = 0; i < 198; i++) begin
            tick2();
            if (achieve2) ach_seen++;
        end
        chk("sat_ach_count", 32'(ach_seen), 32'd9);
        chk("sat_reach_99",  32'(digits2),  32'h99);
        ach_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick2();
            if (achieve2) ach_seen++;
        end
        chk("sat_hold_99", 32'(digits2),  32'h99);
        chk("sat_no_ach",  32'(ach_seen), 32'd0);

        // Reset during ON on dut2
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) tick2();
        chk("dut2_ach10_pulse", 32'(achieve2), 32'd1);
        chk("dut2_ach10_paint", 32'(paint2),   32'd0);
        repeat (2) tick2();
        chk("dut2_on_paint",    32'(paint2),  32'd1);
        chk("dut2_on_snapshot", 32'(digits2), 32'h10);
        @(negedge clk);
        rst     = 1'b1;
        update  = 1'b1;
        update2 = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        update  = 1'b0;
        update2 = 1'b0;
        chk("rst_on_digits2",  32'(digits2),  32'h0);
        chk("rst_on_paint2",   32'(paint2),   32'd1);
        chk("rst_on_achieve2", 32'(achieve2), 32'd0);
        chk("rst_on_digits",   32'(digits),   32'h0);
        chk("rst_on_paint",    32'(paint),    32'd1);
        chk("rst_on_achieve",  32'(achieve),  32'd0);
`ifdef SCORE_METER_HI_EN
        chk("rst_on_hi",       32'(hi_digits), 32'h0);
        chk("rst_on_hi_valid", 32'(hi_valid),  32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/score_meter.md
SCORE_METER -- requirements
Module: score_meter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 5, giving the number of BCD score digits (2..8).
REQ-002 The block SHALL have parameter SPEED_W, default 15, giving the speed input width.
REQ-003 The block SHALL have parameter COEFF, default 40960, giving the accumulated speed per score unit (speed < COEFF guaranteed by the driver).
REQ-004 The block SHALL have parameter ACH_POW, default 2, giving the achievement step of 10**ACH_POW (1 <= ACH_POW < DIGITS).
REQ-005 The block SHALL have parameter FLASH_FRAMES, default 15, giving update ticks per flash half-period.
REQ-006 The block SHALL have parameter FLASH_COUNT, default 3, giving the number of off/on flash cycles per achievement.
REQ-007 The ports SHALL be: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-008 The ports SHALL continue: update  in  1  one-cycle frame tick; speed  in  SPEED_W  current scroll speed; clear  in  1  new-game pulse.
REQ-009 The ports SHALL continue: digits  out  DIGITS x 4  displayed BCD, index 0 most significant; paint  out  1  draw-enable; achieve  out  1  one-cycle pulse on achievement.
REQ-010 Under SCORE_METER_HI_EN the block SHALL add ports: hi_digits  out  DIGITS x 4  high score BCD; hi_valid  out  1  high score nonzero.

Function
REQ-011 Score SHALL be held as DIGITS BCD counters, and no divider or modulo SHALL be used.
REQ-012 The accumulator SHALL be wide enough for COEFF-1+2**SPEED_W-1 without overflow.
REQ-013 On update with speed != 0: if acc+speed < COEFF then acc <= acc+speed, else acc <= acc+speed-COEFF and score increments by 1 in the same cycle.
REQ-014 The increment SHALL ripple BCD carry, and score SHALL saturate at all-9s (further increments ignored, no achievement).
REQ-015 An achievement SHALL fire on the cycle an increment leaves the low ACH_POW digits all zero; achieve pulses and the new score is latched into the snapshot.
REQ-016 The flash FSM SHALL have states IDLE, OFF and ON, with a frame counter and an iteration counter.
REQ-017 In IDLE with an achievement, the FSM SHALL go to OFF with counters zeroed.
REQ-018 In OFF, paint SHALL be 0; after FLASH_FRAMES update ticks the FSM SHALL go to ON.
REQ-019 In ON, paint SHALL be 1; after FLASH_FRAMES ticks the iteration count SHALL increment, and the FSM SHALL go to IDLE if the count reaches FLASH_COUNT, else to OFF.
REQ-020 A new achievement during OFF or ON SHALL restart at OFF with counters zeroed and the new snapshot.
REQ-021 digits SHALL show the snapshot while the FSM is not IDLE, and the live score otherwise.
REQ-022 With speed == 0: acc and score freeze, the FSM forces IDLE, and paint = 1 (crash/pause display).
REQ-023 clear SHALL zero score, acc and snapshot and force IDLE; clear has priority over a simultaneous update.
REQ-024 The FSM frame counter SHALL advance only on update, never on plain clock cycles.

Reset
REQ-025 rst SHALL set score, acc and snapshot to 0, FSM to IDLE, paint = 1, achieve = 0, and digits all 0.
REQ-026 rst SHALL override clear and update, including mid-flash.
REQ-027 Under SCORE_METER_HI_EN, rst SHALL clear the high score; clear SHALL NOT.

Configuration
REQ-028 With SCORE_METER_HI_EN defined, on clear (or on speed falling to 0) the high score SHALL load the score if score > high score, using a BCD digit-wise compare from the MSB.
REQ-029 Without SCORE_METER_HI_EN, the hi_digits/hi_valid ports and the high-score register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 Package score_meter_pkg SHALL hold the default parameters, the FSM state enum (IDLE/OFF/ON) and the BCD digit typedef (logic[3:0]).
REQ-031 One sub-module bcd_counter SHALL provide a DIGITS-wide increment with saturation, a carry-out and a low-zero flag for ACH_POW.

Verification
REQ-032 rst, then speed=4096 with 10 updates -> score 00001 on the 10th update, acc = 0, no achieve.
REQ-033 Preload score 00099, acc 40000, speed 4096, update -> digits 00100, achieve pulse, paint 0 for 15 updates, then 1 for 15 updates; the cycle repeats 3 times, then IDLE.
REQ-034 Score 99999 with further increments -> remains 99999, no achieve.
REQ-035 Mid-flash (OFF), speed=0 -> paint 1 the next cycle, FSM IDLE, digits show live score.
REQ-036 clear and update together at score 00350 -> score 00000; with SCORE_METER_HI_EN, hi_digits = 00350 and hi_valid = 1.
REQ-037 rst asserted during ON state -> all outputs at reset values the next cycle; with SCORE_METER_HI_EN, hi_digits = 00000.
